// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: word serializer feeding an overlapping programmable pattern matcher with match counter and threshold irq
// Ports: clk/rst (async active-low), cfg_we/cfg_pattern/cfg_len/cfg_thresh config write (idle only, bad writes pulse cfg_err),
// in_valid/in_data/in_ready word handshake, clr_cnt clears count and irq, busy while shifting,
// match_pulse/match_cnt/irq match reporting. Define SEQ_DET_CTRL_MATCH_POS_EN to add match_pos (bit_idx of the completing bit).
module seq_det_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 8,
  parameter int LEN_W  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [PAT_W-1:0]          cfg_pattern,
  input  logic [LEN_W-1:0]          cfg_len,
  input  logic [CNT_W-1:0]          cfg_thresh,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  input  logic                      clr_cnt,
  output logic                      busy,
  output logic                      match_pulse,
  output logic [CNT_W-1:0]          match_cnt,
  output logic                      irq,
`ifdef SEQ_DET_CTRL_MATCH_POS_EN
  output logic [$clog2(DATA_W)-1:0] match_pos,
`endif
  output logic                      cfg_err
);
  localparam int IW = $clog2(DATA_W);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [IW-1:0] bit_idx_q, bit_idx_d, pos_q, pos_d;
  logic [PAT_W-1:0] hist_q, hist_d, pat_q, pat_d, mask;
  logic [LEN_W-1:0] fill_q, fill_d, len_q, len_d;
  logic [CNT_W-1:0] thr_q, thr_d, cnt_q, cnt_d;
  logic irq_q, irq_d, mp_q, mp_d, err_q, err_d;
  logic accept, shifting, cfg_ok, match, inc;
  assign in_ready    = state_q == IDLE || bit_idx_q == '0;
  assign busy        = state_q == SHIFT;
  assign match_pulse = mp_q;
  assign match_cnt   = cnt_q;
  assign irq         = irq_q;
  assign cfg_err     = err_q;
`ifdef SEQ_DET_CTRL_MATCH_POS_EN
  assign match_pos   = pos_q;
`endif
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) mask[i] = i < int'(len_q);
    accept    = in_valid && in_ready;
    shifting  = state_q == SHIFT;
    // config only lands while idle, so it never collides with a bit being consumed
    cfg_ok    = cfg_we && state_q == IDLE && cfg_len != '0 && cfg_len <= LEN_W'(PAT_W);
    pat_d     = cfg_ok ? cfg_pattern : pat_q;
    len_d     = cfg_ok ? cfg_len : len_q;
    thr_d     = cfg_ok ? cfg_thresh : thr_q;
    hist_d    = cfg_ok ? '0 : shifting ? (hist_q << 1) | PAT_W'(sh_q[DATA_W-1]) : hist_q;
    fill_d    = cfg_ok ? '0 : shifting && fill_q < LEN_W'(PAT_W) ? fill_q + 1'b1 : fill_q;
    match     = shifting && fill_d >= len_q && ((hist_d ^ pat_q) & mask) == '0;
    // a saturated counter only "increments" when clr_cnt restarts it at 1
    inc       = match && (clr_cnt || cnt_q != '1);
    cnt_d     = match && clr_cnt ? CNT_W'(1) : clr_cnt ? '0 : inc ? cnt_q + 1'b1 : cnt_q;
    irq_d     = inc && thr_q != '0 && cnt_d == thr_q ? 1'b1 : clr_cnt ? 1'b0 : irq_q;
    state_d   = accept ? SHIFT : shifting && bit_idx_q == '0 ? IDLE : state_q;
    sh_d      = accept ? in_data : shifting ? sh_q << 1 : sh_q;
    bit_idx_d = accept ? IW'(DATA_W - 1) : shifting ? bit_idx_q - 1'b1 : bit_idx_q;
    mp_d      = match;
    err_d     = cfg_we && !cfg_ok;
    pos_d     = match ? bit_idx_q : pos_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      bit_idx_q <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      pat_q     <= PAT_W'(4'b1010);
      len_q     <= LEN_W'(4);
      thr_q     <= '0;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
      mp_q      <= 1'b0;
      err_q     <= 1'b0;
      pos_q     <= '0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_idx_q <= bit_idx_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      thr_q     <= thr_d;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
      mp_q      <= mp_d;
      err_q     <= err_d;
      pos_q     <= pos_d;
    end
endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: directed scoreboard bench for seq_det_ctrl
module tb_seq_det_ctrl;
  localparam int DW = 8, PW = 4, CW = 8, LW = 3;
  logic clk = 0, rst = 0, cfg_we = 0, in_valid = 0, clr_cnt = 0;
  logic [PW-1:0] cfg_pattern = '0;
  logic [LW-1:0] cfg_len = '0;
  logic [CW-1:0] cfg_thresh = '0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, busy, match_pulse, irq, cfg_err;
  logic [CW-1:0] match_cnt;
`ifdef SEQ_DET_CTRL_MATCH_POS_EN
  logic [2:0] match_pos;
`endif
  seq_det_ctrl #(.DATA_W(DW), .PAT_W(PW), .CNT_W(CW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_thresh(cfg_thresh), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .clr_cnt(clr_cnt), .busy(busy), .match_pulse(match_pulse), .match_cnt(match_cnt), .irq(irq),
`ifdef SEQ_DET_CTRL_MATCH_POS_EN
    .match_pos(match_pos),
`endif
    .cfg_err(cfg_err));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_fail = 0;
  typedef struct {int cyc; int cnt; bit irq; int pos;} exp_t;
  exp_t sb[$];
  int m_hist, m_fill, m_pat, m_len, m_thr, m_cnt;
  bit m_irq;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic model_reset();
    m_hist = 0; m_fill = 0; m_pat = 'b1010; m_len = 4; m_thr = 0; m_cnt = 0; m_irq = 0;
  endtask
  bit mon_p;
  exp_t mon_e;
  always @(negedge clk) begin
    mon_p = sb.size() > 0 && sb[0].cyc == cyc;
    chk("match_pulse", match_pulse, mon_p);
    if (mon_p) begin
      mon_e = sb.pop_front();
      chk("match_cnt_at_pulse", match_cnt, mon_e.cnt);
      chk("irq_at_pulse", irq, mon_e.irq);
`ifdef SEQ_DET_CTRL_MATCH_POS_EN
      chk("match_pos", match_pos, mon_e.pos);
`endif
    end
  end
  task automatic send(input logic [7:0] w, input bit clr_last);
    int n = 0, e;
    bit hit, inc, cl;
    in_valid = 1; in_data = w;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_timeout", n < 50, 1);
    @(negedge clk);
    in_valid = 0;
    e = cyc;
    for (int k = 1; k <= 8; k++) begin
      m_hist = ((m_hist << 1) | w[8-k]) & 15;
      if (m_fill < PW) m_fill++;
      hit = m_fill >= m_len && (((m_hist ^ m_pat) & ((1 << m_len) - 1)) == 0);
      cl = clr_last && k == 8;
      if (hit) begin
        inc = 1;
        if (cl) m_cnt = 1; else if (m_cnt < 255) m_cnt++; else inc = 0;
        if (inc && m_thr != 0 && m_cnt == m_thr) m_irq = 1; else if (cl) m_irq = 0;
        sb.push_back('{e + k, m_cnt, m_irq, 8 - k});
      end else if (cl) begin
        m_cnt = 0; m_irq = 0;
      end
    end
  endtask
  task automatic drain();
    int n = 0;
    while ((sb.size() > 0 || busy) && n < 3000) begin @(negedge clk); n++; end
    chk("drain_timeout", n < 3000, 1);
    @(negedge clk);
    chk("match_cnt_idle", match_cnt, m_cnt);
    chk("irq_idle", irq, m_irq);
  endtask
  task automatic cfg(input logic [3:0] p, input logic [2:0] l, input logic [7:0] t, input bit exp_err);
    cfg_we = 1; cfg_pattern = p; cfg_len = l; cfg_thresh = t;
    @(negedge clk);
    cfg_we = 0;
    chk("cfg_err", cfg_err, exp_err);
    if (!exp_err) begin m_pat = p; m_len = l; m_thr = t; m_hist = 0; m_fill = 0; end
    @(negedge clk);
    chk("cfg_err_one_cycle", cfg_err, 0);
  endtask
  task automatic clear();
    clr_cnt = 1;
    @(negedge clk);
    clr_cnt = 0;
    m_cnt = 0; m_irq = 0;
    chk("clr_cnt", match_cnt, m_cnt);
    chk("clr_irq", irq, m_irq);
  endtask
  initial begin
    int nb, nr;
    model_reset();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_irq", irq, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst = 1;
    @(negedge clk);
    // 1: default pattern, one word
    send(8'hAA, 0);
    nb = 0; nr = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) nb++;
      if (!in_ready) nr++;
      @(negedge clk);
    end
    chk("busy_cycles", nb, 8);
    chk("ready_low_cycles", nr, 7);
    drain();
    // 2: back-to-back words from fresh history
    cfg(4'b1010, 3'd4, 8'd0, 0);
    clear();
    send(8'hAA, 0);
    send(8'hAA, 0);
    drain();
    // 3: new pattern with threshold
    clear();
    cfg(4'b0110, 3'd3, 8'd2, 0);
    send(8'h36, 0);
    drain();
    clear();
    // 4: rejected config writes
    cfg(4'b1010, 3'd4, 8'd0, 0);
    cfg(4'b0001, 3'd0, 8'd5, 1);
    send(8'hAA, 0);
    cfg(4'b0001, 3'd2, 8'd5, 1);
    drain();
    // 5: saturation, then clr_cnt coinciding with a match
    clear();
    for (int i = 0; i < 128; i++) send(8'hAA, 0);
    drain();
    send(8'h0A, 1);
    repeat (7) @(negedge clk);
    clr_cnt = 1;
    @(negedge clk);
    clr_cnt = 0;
    drain();
    // 6: reset in the middle of a word
    send(8'hAA, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    sb.delete();
    model_reset();
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_cnt", match_cnt, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    send(8'h0A, 0);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Stream controller and scheduler for the serial pattern detector path. Accepts parallel words over a valid/ready handshake and serializes them MSB-first into a programmable overlapping pattern matcher (reset pattern 1010). Counts matches and raises a sticky threshold interrupt. Pattern, length and threshold are configured through a write strobe that is legal only while idle.

Parameters:
DATA_W, 8, input word width (>=2)
PAT_W, 4, maximum pattern length in bits
CNT_W, 8, match counter width
LEN_W, 3, width of cfg_len; must satisfy 2**LEN_W > PAT_W

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
cfg_we  input  1  configuration write strobe
cfg_pattern  input  PAT_W  pattern; the low cfg_len bits are used, MSB of that field is matched first
cfg_len  input  LEN_W  pattern length, legal range 1..PAT_W
cfg_thresh  input  CNT_W  irq threshold; 0 disables irq
in_valid  input  1  word valid
in_data  input  DATA_W  word to serialize
in_ready  output  1  controller can accept a word this cycle
clr_cnt  input  1  synchronous clear of match_cnt and irq
busy  output  1  FSM in SHIFT
match_pulse  output  1  one-cycle pulse per detected match
match_cnt  output  CNT_W  saturating match count
irq  output  1  sticky threshold-reached flag
cfg_err  output  1  one-cycle pulse on a rejected config write

Behaviour:
- Reset: state=IDLE; pattern=1010 (zero-extended to PAT_W); len=4; thresh=0; history=0; fill=0; all outputs 0 except in_ready=1.
- FSM states are IDLE and SHIFT.
  - in_ready = IDLE, or SHIFT with bit_idx==0.
  - Accept = in_valid & in_ready. On accept: load the shift register with in_data, set bit_idx=DATA_W-1, go to SHIFT.
  - In SHIFT, one bit per cycle, MSB first. At each edge the bit enters history (shift left, new bit at LSB) and bit_idx decrements.
  - At bit_idx==0: on accept, reload and stay in SHIFT (back-to-back, no bubble); otherwise return to IDLE.
  - Throughput is DATA_W cycles per word. First bit of an accepted word is consumed at the first edge after acceptance.
- Match logic:
  - fill counts consumed bits and saturates at PAT_W.
  - A match occurs when fill >= len and history[len-1:0] == pattern[len-1:0], evaluated on next-state history. Overlapping matches are counted.
  - History and fill persist across words and idle gaps.
  - match_pulse is registered: it is high in the cycle after the edge at which the completing bit entered history. match_cnt updates on that same edge.
- Counter:
  - Increments by 1 per match and saturates at 2**CNT_W-1, with no wrap.
  - clr_cnt alone sets count to 0. clr_cnt together with a match sets count to 1.
- irq:
  - Set on the edge where the count becomes equal to a nonzero thresh through an increment.
  - Stays set until clr_cnt.
  - If clr_cnt and a set condition occur in the same cycle, the set wins (count becomes 1 and thresh==1).
- Config:
  - cfg_we in IDLE with 1<=cfg_len<=PAT_W loads pattern, len and thresh, and clears history and fill. It does not clear match_cnt or irq.
  - cfg_we while busy, or with an illegal cfg_len, is ignored; cfg_err pulses high for 1 cycle.
  - cfg_we in the same cycle as an accept from IDLE is applied first (the new word uses the new config).
- Reset mid-word drops the word and returns every register to its reset value immediately.

Optional Feature:
Macro SEQ_DET_CTRL_MATCH_POS_EN.
- Defined: adds output match_pos [$clog2(DATA_W)-1:0], reset 0. On every match it is loaded with the bit_idx of the completing bit (DATA_W-1 = word MSB) and holds until the next match.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
1. Defaults, single word 0xAA, then idle -> 3 match_pulses on the 4th, 6th and 8th bit edges; match_cnt=3; busy for 8 cycles; in_ready low for 7 cycles.
2. Back-to-back 0xAA, 0xAA with in_valid held -> no bubble between words; 7 matches total (the boundary-spanning match is counted); match_cnt=7.
3. cfg_we with pattern=0110, len=3, thresh=2, then word 0x36 -> 2 matches; irq rises on the edge of the 2nd match; clr_cnt -> match_cnt=0, irq=0.
4. cfg_we during SHIFT, and cfg_we with len=0 while idle -> cfg_err 1-cycle pulse each time; pattern stays 1010; later 0xAA still gives 3 matches.
5. Stream 128 words of 0xAA -> match_cnt saturates at 255 and stays there; clr_cnt asserted on a match cycle -> match_cnt=1.
6. Assert rst low after the 3rd bit of 0xAA, release, send 0x0A -> no residual history; exactly 1 match (the final 1010 of 0x0A); match_cnt=1.
